// File: rtl/datamem_pkg.sv
// datamem_pkg: shared types and helpers for the data-memory responder.
// Optional feature macro used by the responder: DATAMEM_ALIGN_CHECK_EN.
package datamem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] SZ_BYTE   = 4'd1;
  localparam logic [3:0] SZ_HALF   = 4'd2;
  localparam logic [3:0] SZ_WORD   = 4'd4;
  localparam logic [3:0] SZ_DOUBLE = 4'd8;

  // Only naturally sized power-of-two transfers are meaningful
  function automatic logic size_legal(input logic [3:0] sz);
    return (sz == SZ_BYTE) || (sz == SZ_HALF) || (sz == SZ_WORD) || (sz == SZ_DOUBLE);
  endfunction

  // Lane i enabled when byte i is part of the transfer; illegal sizes touch nothing
  function automatic logic [7:0] byte_mask(input logic [3:0] sz);
    case (sz)
      SZ_BYTE:   return 8'h01;
      SZ_HALF:   return 8'h03;
      SZ_WORD:   return 8'h0F;
      SZ_DOUBLE: return 8'hFF;
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/datamem_responder_if.sv
// datamem_responder_if: MEM-stage request/response bundle.
// err only exists when DATAMEM_ALIGN_CHECK_EN is defined.
interface datamem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] address;
  logic        write_enable;
  logic        read_enable;
  logic [63:0] write_data;
  logic [3:0]  xfer_size;
  logic        resp_valid;
  logic [63:0] read_data;
  logic        busy;
`ifdef DATAMEM_ALIGN_CHECK_EN
  logic        err;
`endif

  modport slave (
    input  req_valid, address, write_enable, read_enable, write_data, xfer_size,
`ifdef DATAMEM_ALIGN_CHECK_EN
    output err,
`endif
    output req_ready, resp_valid, read_data, busy
  );

  modport master (
    output req_valid, address, write_enable, read_enable, write_data, xfer_size,
`ifdef DATAMEM_ALIGN_CHECK_EN
    input  err,
`endif
    input  req_ready, resp_valid, read_data, busy
  );
endinterface

// File: rtl/datamem_lane_merge.sv
// datamem_lane_merge: masks per-lane bytes into a zero-extended 64-bit load word.
module datamem_lane_merge (
  input  logic [7:0][7:0] i_bytes,
  input  logic [7:0]      i_mask,
  output logic [63:0]     o_word
);
  for (genvar g = 0; g < 8; g++) begin : g_lane
    assign o_word[8*g +: 8] = i_mask[g] ? i_bytes[g] : 8'h00;
  end
endmodule

// File: rtl/datamem_responder.sv
// datamem_responder: fixed-latency, one-outstanding data-memory responder.
// Define DATAMEM_ALIGN_CHECK_EN to reject misaligned / illegal-size requests with err.
module datamem_responder
  import datamem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 3
) (
  input  logic               clk,
  input  logic               reset,
  datamem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_addr;
  logic            r_we, r_re;
  logic [63:0]     r_wdata;
  logic [3:0]      r_size;
  logic [63:0]     r_rdata;
  logic [7:0]      r_mem [DEPTH_BYTES];

  logic            w_accept, w_access, w_ok;
  logic [7:0]      w_mask;
  logic [7:0][7:0] w_rd_bytes;
  logic [63:0]     w_merged;
  logic [AW-1:0]   w_idx [8];

  assign w_accept = (r_state == IDLE) && bus.req_valid;
  assign w_access = (r_state == BUSY) && (r_cnt == '0);

`ifdef DATAMEM_ALIGN_CHECK_EN
  // For legal sizes size-1 masks the offset bits; size 8 wraps to 3'b111 as needed
  logic w_aligned;
  assign w_aligned = (r_addr[2:0] & (r_size[2:0] - 3'd1)) == 3'd0;
  assign w_ok      = size_legal(r_size) && w_aligned;
`else
  assign w_ok      = size_legal(r_size);
`endif

  assign w_mask = w_ok ? byte_mask(r_size) : 8'h00;

  // Index arithmetic wraps naturally because DEPTH_BYTES is a power of two
  for (genvar g = 0; g < 8; g++) begin : g_idx
    assign w_idx[g]      = r_addr + AW'(g);
    assign w_rd_bytes[g] = r_mem[w_idx[g]];
  end

  datamem_lane_merge u_merge (
    .i_bytes (w_rd_bytes),
    .i_mask  (w_mask),
    .o_word  (w_merged)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid) w_next = BUSY;
      BUSY:    if (r_cnt == '0)   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latency counter: loaded on acceptance, counts down while BUSY
  always_ff @(posedge clk) begin
    if (reset)                               r_cnt <= '0;
    else if (w_accept)                       r_cnt <= CW'(LATENCY - 1);
    else if (r_state == BUSY && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // Request capture; inputs are ignored outside the acceptance edge
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= bus.address[AW-1:0];
      r_we    <= bus.write_enable;
      r_re    <= bus.read_enable;
      r_wdata <= bus.write_data;
      r_size  <= bus.xfer_size;
    end
  end

  // Store on the access edge; a reset on that edge cancels it
  always_ff @(posedge clk) begin
    if (!reset && w_access && r_we) begin
      for (int i = 0; i < 8; i++)
        if (w_mask[i]) r_mem[w_idx[i]] <= r_wdata[8*i +: 8];
    end
  end

  // Load data: sampled pre-write, held until the next response
  always_ff @(posedge clk) begin
    if (reset)         r_rdata <= '0;
    else if (w_access) r_rdata <= r_re ? w_merged : 64'h0;
  end

`ifdef DATAMEM_ALIGN_CHECK_EN
  logic r_err;
  // Error flag accompanies the response of a rejected request
  always_ff @(posedge clk) begin
    if (reset)         r_err <= 1'b0;
    else if (w_access) r_err <= !w_ok;
  end
  assign bus.err = r_err;
`endif

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.read_data  = r_rdata;

endmodule

// File: tb/tb_datamem_responder.sv
// tb_datamem_responder: scoreboard bench for datamem_responder (default or DATAMEM_ALIGN_CHECK_EN build).
module tb_datamem_responder;
  localparam int D = 1024;
  localparam int L = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  datamem_responder_if bus();

  datamem_responder #(.DEPTH_BYTES(D), .LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        chk_rd;
    logic [63:0] rd;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef DATAMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  task automatic drive(input logic [63:0] a, input logic we, input logic re,
                       input logic [63:0] wd, input logic [3:0] sz);
    bus.req_valid    = 1'b1;
    bus.address      = a;
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.write_data   = wd;
    bus.xfer_size    = sz;
  endtask

  // One request end to end: acceptance, latency, response contents, single-cycle strobe
  task automatic do_req(input string name, input logic [63:0] a, input logic we, input logic re,
                        input logic [63:0] wd, input logic [3:0] sz,
                        input logic chk_rd, input logic [63:0] exp_rd, input logic exp_err);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    n_chk++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_ready: got %b expected 1", name, bus.req_ready);
    end
    drive(a, we, re, wd, sz);
    e.chk_rd = chk_rd; e.rd = exp_rd; e.er = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the responder must ignore them
    bus.req_valid    = 1'b0;
    bus.address      = ~a;
    bus.write_enable = ~we;
    bus.read_enable  = ~re;
    bus.write_data   = ~wd;
    bus.xfer_size    = 4'd8;
    w = 0;
    do begin @(negedge clk); w++; end while (!bus.resp_valid && w < 20);
    n_chk++;
    if (w !== L + 1) begin
      n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, w, L + 1);
    end
    if (bus.resp_valid === 1'b1) begin
      e = sb.pop_front();
      if (e.chk_rd) begin
        n_chk++;
        if (bus.read_data !== e.rd) begin
          n_fail++; $display("FAIL %s_data: got %h expected %h", name, bus.read_data, e.rd);
        end
      end
`ifdef DATAMEM_ALIGN_CHECK_EN
      n_chk++;
      if (bus.err !== e.er) begin
        n_fail++; $display("FAIL %s_err: got %b expected %b", name, bus.err, e.er);
      end
`endif
    end else begin
      void'(sb.pop_front());
      n_fail++; $display("FAIL %s_timeout: got no resp_valid expected one", name);
    end
    @(negedge clk);
    n_chk++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_pulse: got %b expected 0", name, bus.resp_valid);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.address = '0; bus.write_enable = 1'b0;
    bus.read_enable = 1'b0; bus.write_data = '0; bus.xfer_size = 4'd1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if ({bus.req_ready, bus.busy, bus.resp_valid} !== 3'b100) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 100", {bus.req_ready, bus.busy, bus.resp_valid});
    end
    n_chk++;
    if (bus.read_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.read_data);
    end
`ifdef DATAMEM_ALIGN_CHECK_EN
    n_chk++;
    if (bus.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err);
    end
`endif
  endtask

  task automatic test_store_load();
    do_req("st8", 64'd16, 1, 0, 64'h0123456789ABCDEF, 4'd8, 0, 64'h0, 0);
    do_req("ld8", 64'd16, 0, 1, 64'h0, 4'd8, 1, 64'h0123456789ABCDEF, 0);
  endtask

  task automatic test_sizes();
    do_req("ld1", 64'd16, 0, 1, 64'h0, 4'd1, 1, 64'hEF, 0);
    do_req("ld2", 64'd18, 0, 1, 64'h0, 4'd2, 1, 64'h89AB, 0);
    do_req("none", 64'd16, 0, 0, 64'h5555, 4'd8, 1, 64'h0, 0);
  endtask

  task automatic test_rmw();
    do_req("rmw", 64'd16, 1, 1, 64'hFFFFFFFF, 4'd4, 1, 64'h89ABCDEF, 0);
    do_req("rmw_ld", 64'd16, 0, 1, 64'h0, 4'd8, 1, 64'h01234567FFFFFFFF, 0);
  endtask

  task automatic test_wrap();
    do_req("st_zero", 64'd0, 1, 0, 64'h1122334455667788, 4'd8, 0, 64'h0, 0);
    do_req("st_wrap", 64'(D - 2), 1, 0, 64'hAABBCCDD, 4'd4, ALIGN, 64'h0, ALIGN);
    do_req("ld_wrap0", 64'd0, 0, 1, 64'h0, 4'd1, 1, ALIGN ? 64'h88 : 64'hBB, 0);
    do_req("ld_wrap2", 64'(D - 1), 0, 1, 64'h0, 4'd2, 1, ALIGN ? 64'h0 : 64'hBBCC, ALIGN);
  endtask

  // Reset lands while the store is BUSY with cnt = 1
  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    drive(64'd16, 1, 0, 64'hDEADBEEFDEADBEEF, 4'd8);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if ({bus.req_ready, bus.busy, bus.resp_valid} !== 3'b100) begin
      n_fail++; $display("FAIL rstmid_ctrl: got %b expected 100", {bus.req_ready, bus.busy, bus.resp_valid});
    end
    seen = 0;
    repeat (8) begin @(negedge clk); if (bus.resp_valid === 1'b1) seen++; end
    n_chk++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL rstmid_resp: got %0d pulses expected 0", seen);
    end
    do_req("rstmid_ld", 64'd16, 0, 1, 64'h0, 4'd8, 1, 64'h01234567FFFFFFFF, 0);
  endtask

  // req_valid held high across three requests
  task automatic test_back_to_back();
    logic [63:0] ra [3];
    logic [3:0]  rs [3];
    logic [63:0] rx [3];
    logic        re [3];
    int issued, resp, busy_bad, cyc;
    exp_t e;
    ra = '{64'd16, 64'd16, 64'd20};
    rs = '{4'd8, 4'd3, 4'd2};
    rx = '{64'h01234567FFFFFFFF, 64'h0, 64'h4567};
    re = '{1'b0, ALIGN, 1'b0};
    issued = 0; resp = 0; busy_bad = 0; cyc = 0;
    while ((issued < 3 || resp < 3) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.busy !== !bus.req_ready) busy_bad++;
      if (bus.resp_valid === 1'b1) begin
        resp++;
        if (sb.size() == 0) begin
          n_chk++; n_fail++; $display("FAIL b2b_extra: got extra response expected none");
        end else begin
          e = sb.pop_front();
          n_chk++;
          if (bus.read_data !== e.rd) begin
            n_fail++; $display("FAIL b2b_data: got %h expected %h", bus.read_data, e.rd);
          end
`ifdef DATAMEM_ALIGN_CHECK_EN
          n_chk++;
          if (bus.err !== e.er) begin
            n_fail++; $display("FAIL b2b_err: got %b expected %b", bus.err, e.er);
          end
`endif
        end
      end
      if (bus.req_ready === 1'b1) begin
        if (issued < 3) begin
          drive(ra[issued], 0, 1, 64'h0, rs[issued]);
          e.chk_rd = 1'b1; e.rd = rx[issued]; e.er = re[issued];
          sb.push_back(e);
          issued++;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) resp++;
    end
    n_chk++;
    if (resp !== 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d pulses expected 3", resp);
    end
    n_chk++;
    if (busy_bad !== 0) begin
      n_fail++; $display("FAIL b2b_busy: got %0d bad cycles expected 0", busy_bad);
    end
    n_chk++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL b2b_pending: got %0d left expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_sizes();
    test_rmw();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
